// File: rtl/csr_commit.sv
// csr_commit: sequences one CSR / ECALL / MRET instruction through read, write, trap and flush.
module csr_commit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [2:0]      in_funct3,
    input  logic [11:0]     in_csr_addr,
    input  logic [4:0]      in_rs1_idx,
    input  logic [XLEN-1:0] in_rs1_val,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_pc,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic [11:0]     csr_waddr,
    output logic            csr_wen,
    output logic [XLEN-1:0] csr_wdata,
    output logic [1:0]      csr_excep_op,
    output logic [XLEN-1:0] csr_pc,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    output logic            rd_wen,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);
    typedef enum logic [2:0] {IDLE, READ, WRITE, TRAP, FLUSH} state_t;
    localparam logic [1:0] K_CSR = 2'd0, K_ECALL = 2'd1, K_RSV = 2'd3;
    state_t          state_q, state_d;
    logic [1:0]      kind_q, kind_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [11:0]     addr_q, addr_d;
    logic [4:0]      rs1_idx_q, rs1_idx_d, rd_q, rd_d;
    logic [XLEN-1:0] rs1_val_q, rs1_val_d, pc_q, pc_d, old_q, old_d, target_q, target_d;
    logic [1:0]      op;
    logic [XLEN-1:0] src;
    assign op  = funct3_q[1:0];
    assign src = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    // next-state, field latching and per-state output pulses; everything forced quiet while reset is high
    always_comb begin
        state_d        = state_q;
        kind_d         = kind_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        rs1_idx_d      = rs1_idx_q;
        rs1_val_d      = rs1_val_q;
        rd_d           = rd_q;
        pc_d           = pc_q;
        old_d          = old_q;
        target_d       = target_q;
        in_ready       = 1'b0;
        csr_raddr      = addr_q;
        csr_waddr      = addr_q;
        csr_wen        = 1'b0;
        csr_wdata      = '0;
        csr_excep_op   = 2'd0;
        csr_pc         = pc_q;
        rd_wen         = 1'b0;
        rd_addr        = rd_q;
        rd_data        = old_q;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = target_q;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    kind_d    = in_kind;
                    funct3_d  = in_funct3;
                    addr_d    = in_csr_addr;
                    rs1_idx_d = in_rs1_idx;
                    rs1_val_d = in_rs1_val;
                    rd_d      = in_rd;
                    pc_d      = in_pc;
                    if (in_kind == K_RSV) target_d = in_pc + XLEN'(4);
                    state_d = in_kind == K_CSR ? READ : in_kind == K_RSV ? FLUSH : TRAP;
                end
            end
            READ: begin
                old_d   = csr_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                csr_wen   = op == 2'b01 || (op[1] && rs1_idx_q != 5'd0);
                csr_wdata = op == 2'b01 ? src : op == 2'b10 ? (old_q | src) : (old_q & ~src);
                rd_wen    = rd_q != 5'd0 && op != 2'b00;
                target_d  = pc_q + XLEN'(4);
                state_d   = FLUSH;
            end
            TRAP: begin
                csr_excep_op = kind_q == K_ECALL ? 2'd1 : 2'd2;
                target_d     = kind_q == K_ECALL ? (csr_mtvec & ~XLEN'(3)) : csr_mepc;
                state_d      = FLUSH;
            end
            FLUSH: begin
                flush          = 1'b1;
                redirect_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            in_ready       = 1'b0;
            csr_raddr      = '0;
            csr_waddr      = '0;
            csr_wen        = 1'b0;
            csr_wdata      = '0;
            csr_excep_op   = 2'd0;
            csr_pc         = '0;
            rd_wen         = 1'b0;
            rd_addr        = '0;
            rd_data        = '0;
            flush          = 1'b0;
            redirect_valid = 1'b0;
            redirect_pc    = '0;
        end
    end
    // state and latched instruction fields; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            kind_q    <= '0;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_idx_q <= '0;
            rs1_val_q <= '0;
            rd_q      <= '0;
            pc_q      <= '0;
            old_q     <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rs1_idx_q <= rs1_idx_d;
            rs1_val_q <= rs1_val_d;
            rd_q      <= rd_d;
            pc_q      <= pc_d;
            old_q     <= old_d;
            target_q  <= target_d;
        end
    end
endmodule

// File: tb/tb_csr_commit.sv
// tb_csr_commit: randomized and directed checks of csr_commit against a per-instruction behavioural model.
module tb_csr_commit;
    localparam int XL = 64;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, in_valid, in_ready, csr_wen, rd_wen, flush, redirect_valid;
    logic [1:0] in_kind, csr_excep_op;
    logic [2:0] in_funct3;
    logic [11:0] in_csr_addr, csr_raddr, csr_waddr;
    logic [4:0] in_rs1_idx, in_rd, rd_addr;
    logic [XL-1:0] in_rs1_val, in_pc, csr_rdata, csr_wdata, csr_pc, csr_mtvec, csr_mepc, rd_data, redirect_pc;
    csr_commit #(.XLEN(XL)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_csr_addr(in_csr_addr),
        .in_rs1_idx(in_rs1_idx), .in_rs1_val(in_rs1_val), .in_rd(in_rd), .in_pc(in_pc),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_waddr(csr_waddr), .csr_wen(csr_wen),
        .csr_wdata(csr_wdata), .csr_excep_op(csr_excep_op), .csr_pc(csr_pc),
        .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .rd_wen(rd_wen), .rd_addr(rd_addr),
        .rd_data(rd_data), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );
    int chk = 0, err = 0;
    // what one instruction did, cycle numbers counted from the accept cycle (0)
    int o_wen_n, o_wen_c, o_rdw_n, o_rdw_c, o_exc_n, o_exc_c, o_fl_n, o_fl_c, o_rdy, o_bad;
    logic [XL-1:0] o_wdata, o_rd_data, o_csr_pc, o_rpc;
    logic [11:0] o_waddr;
    logic [4:0] o_rd_addr;
    logic [1:0] o_exc_op;
    task automatic run_instr(input logic [1:0] k, input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                             input logic [XL-1:0] v, input logic [4:0] rd, input logic [XL-1:0] pc,
                             input logic [XL-1:0] rdata, input bit hold);
        int c;
        bit done;
        {o_wen_n, o_wen_c, o_rdw_n, o_rdw_c, o_exc_n, o_exc_c, o_fl_n, o_fl_c, o_rdy, o_bad} = '0;
        {o_wdata, o_rd_data, o_csr_pc, o_rpc, o_waddr, o_rd_addr, o_exc_op} = '0;
        in_valid = 1'b1; in_kind = k; in_funct3 = f3; in_csr_addr = a; in_rs1_idx = idx;
        in_rs1_val = v; in_rd = rd; in_pc = pc; csr_rdata = rdata;
        c = 0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            c++;
            if (csr_wen) begin o_wen_n++; o_wen_c = c; o_wdata = csr_wdata; o_waddr = csr_waddr; end
            if (rd_wen) begin o_rdw_n++; o_rdw_c = c; o_rd_addr = rd_addr; o_rd_data = rd_data; end
            if (csr_excep_op != 2'd0) begin o_exc_n++; o_exc_c = c; o_exc_op = csr_excep_op; o_csr_pc = csr_pc; end
            if (flush) begin o_fl_n++; o_fl_c = c; o_rpc = redirect_pc; end
            if (csr_raddr !== a || csr_pc !== pc || flush !== redirect_valid) o_bad++;
            if (in_ready === 1'b1) begin o_rdy = c; done = 1'b1; end
            else if (c >= 8) done = 1'b1;
            in_valid = hold && !done;
            if (hold) begin
                in_kind = 2'($urandom); in_funct3 = 3'($urandom); in_csr_addr = 12'($urandom);
                in_rs1_idx = 5'($urandom); in_rs1_val = {$urandom, $urandom}; in_rd = 5'($urandom);
                in_pc = {$urandom, $urandom};
            end
        end
        in_valid = 1'b0;
    endtask
    task automatic test_reset();
        in_valid = 1'b1; in_kind = 2'd1; in_pc = {$urandom, $urandom}; in_csr_addr = 12'($urandom);
        repeat (3) @(negedge clk);
        chk++;
        if ({csr_wen, rd_wen, csr_excep_op, flush, redirect_valid, csr_raddr, csr_waddr, csr_wdata, csr_pc, rd_addr, rd_data, redirect_pc} !== '0) begin
            err++; $display("FAIL reset_outputs got wen=%b rdw=%b exc=%0d fl=%b rpc=%h exp all zero", csr_wen, rd_wen, csr_excep_op, flush, redirect_pc);
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk++;
        if ({in_ready, csr_wen, rd_wen, flush} !== 4'b1000) begin
            err++; $display("FAIL reset_release got rdy/wen/rdw/fl=%b exp 1000", {in_ready, csr_wen, rd_wen, flush});
        end
    endtask
    task automatic test_directed();
        run_instr(2'd0, 3'b001, 12'h305, 5'd1, 64'h8000_0100, 5'd5, 64'h1000, 64'h40, 1'b0);
        chk++;
        if ({o_wen_c, o_wdata, o_rdw_c, o_rd_data, o_fl_c, o_rpc} !== {32'd2, 64'h8000_0100, 32'd2, 64'h40, 32'd3, 64'h1004}) begin
            err++; $display("FAIL csrrw_mtvec got wc=%0d wd=%h rc=%0d rdd=%h fc=%0d rpc=%h exp 2 80000100 2 40 3 1004", o_wen_c, o_wdata, o_rdw_c, o_rd_data, o_fl_c, o_rpc);
        end
        run_instr(2'd0, 3'b010, 12'h300, 5'd0, 64'hFFFF, 5'd3, 64'h1100, 64'h1800, 1'b0);
        chk++;
        if ({o_wen_n, o_rdw_n, o_rd_addr, o_rd_data} !== {32'd0, 32'd1, 5'd3, 64'h1800}) begin
            err++; $display("FAIL csrrs_x0 got wen_n=%0d rdw_n=%0d rd=%0d rdd=%h exp 0 1 3 1800", o_wen_n, o_rdw_n, o_rd_addr, o_rd_data);
        end
        run_instr(2'd0, 3'b111, 12'h300, 5'd8, 64'h0, 5'd0, 64'h1200, 64'h88, 1'b0);
        chk++;
        if ({o_wen_n, o_wdata, o_rdw_n} !== {32'd1, 64'h80, 32'd0}) begin
            err++; $display("FAIL csrrci got wen_n=%0d wd=%h rdw_n=%0d exp 1 80 0", o_wen_n, o_wdata, o_rdw_n);
        end
        run_instr(2'd0, 3'b001, 12'h340, 5'd2, 64'h55, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0);
        chk++;
        if ({o_fl_n, o_rpc} !== {32'd1, 64'h0}) begin
            err++; $display("FAIL pc_wrap got fl_n=%0d rpc=%h exp 1 0", o_fl_n, o_rpc);
        end
        csr_mtvec = 64'h3001; csr_mepc = 64'h2004;
        run_instr(2'd1, 3'b000, 12'h000, 5'd0, 64'h0, 5'd0, 64'h2000, 64'h0, 1'b0);
        chk++;
        if ({o_exc_c, o_exc_op, o_csr_pc, o_fl_c, o_rpc, o_rdy} !== {32'd1, 2'd1, 64'h2000, 32'd2, 64'h3000, 32'd3}) begin
            err++; $display("FAIL ecall got ec=%0d op=%0d pc=%h fc=%0d rpc=%h rdy=%0d exp 1 1 2000 2 3000 3", o_exc_c, o_exc_op, o_csr_pc, o_fl_c, o_rpc, o_rdy);
        end
        run_instr(2'd2, 3'b000, 12'h000, 5'd0, 64'h0, 5'd0, 64'h2400, 64'h0, 1'b0);
        chk++;
        if ({o_exc_c, o_exc_op, o_fl_c, o_rpc, o_rdy} !== {32'd1, 2'd2, 32'd2, 64'h2004, 32'd3}) begin
            err++; $display("FAIL mret got ec=%0d op=%0d fc=%0d rpc=%h rdy=%0d exp 1 2 2 2004 3", o_exc_c, o_exc_op, o_fl_c, o_rpc, o_rdy);
        end
    endtask
    task automatic test_csr(input int n_ops, input bit hold);
        logic [2:0] f3;
        logic [11:0] a;
        logic [4:0] idx, rd;
        logic [XL-1:0] v, pc, rdata, src, wd;
        logic ew, erw;
        for (int n = 0; n < n_ops; n++) begin
            f3 = 3'($urandom); a = 12'($urandom);
            idx = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            rd = $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom);
            v = {$urandom, $urandom}; pc = {$urandom, $urandom} & ~64'h3; rdata = {$urandom, $urandom};
            run_instr(2'd0, f3, a, idx, v, rd, pc, rdata, hold);
            src = f3[2] ? XL'(idx) : v;
            ew = f3[1:0] == 2'b01 || (f3[1:0] != 2'b00 && idx != 5'd0);
            wd = f3[1:0] == 2'b01 ? src : f3[1:0] == 2'b10 ? (rdata | src) : (rdata & ~src);
            erw = rd != 5'd0 && f3[1:0] != 2'b00;
            chk++;
            if ({o_wen_n, o_wen_c, o_wdata, o_waddr} !== (ew ? {32'd1, 32'd2, wd, a} : 140'd0)) begin
                err++; $display("FAIL csr_write f3=%b idx=%0d got n=%0d c=%0d wd=%h wa=%h exp wen=%b wd=%h wa=%h", f3, idx, o_wen_n, o_wen_c, o_wdata, o_waddr, ew, wd, a);
            end
            chk++;
            if ({o_rdw_n, o_rdw_c, o_rd_addr, o_rd_data} !== (erw ? {32'd1, 32'd2, rd, rdata} : 133'd0)) begin
                err++; $display("FAIL gpr_write f3=%b rd=%0d got n=%0d c=%0d rd=%0d d=%h exp wen=%b d=%h", f3, rd, o_rdw_n, o_rdw_c, o_rd_addr, o_rd_data, erw, rdata);
            end
            chk++;
            if ({o_exc_n, o_fl_n, o_fl_c, o_rpc, o_rdy, o_bad} !== {32'd0, 32'd1, 32'd3, pc + 64'd4, 32'd4, 32'd0}) begin
                err++; $display("FAIL csr_flow got exc=%0d fl=%0d fc=%0d rpc=%h rdy=%0d bad=%0d exp 0 1 3 %h 4 0", o_exc_n, o_fl_n, o_fl_c, o_rpc, o_rdy, o_bad, pc + 64'd4);
            end
        end
    endtask
    task automatic test_trap();
        logic [1:0] k;
        logic [XL-1:0] pc, tgt;
        for (int n = 0; n < 12; n++) begin
            k = 2'($urandom_range(1, 2)); pc = {$urandom, $urandom} & ~64'h3;
            csr_mtvec = {$urandom, $urandom}; csr_mepc = {$urandom, $urandom};
            run_instr(k, 3'($urandom), 12'($urandom), 5'($urandom), {$urandom, $urandom}, 5'($urandom), pc, {$urandom, $urandom}, 1'b0);
            tgt = k == 2'd1 ? {csr_mtvec[XL-1:2], 2'b00} : csr_mepc;
            chk++;
            if ({o_exc_n, o_exc_c, o_exc_op, o_csr_pc} !== {32'd1, 32'd1, k, pc}) begin
                err++; $display("FAIL trap_op got n=%0d c=%0d op=%0d pc=%h exp 1 1 %0d %h", o_exc_n, o_exc_c, o_exc_op, o_csr_pc, k, pc);
            end
            chk++;
            if ({o_wen_n, o_rdw_n, o_fl_n, o_fl_c, o_rpc, o_rdy, o_bad} !== {32'd0, 32'd0, 32'd1, 32'd2, tgt, 32'd3, 32'd0}) begin
                err++; $display("FAIL trap_flow got wen=%0d rdw=%0d fl=%0d fc=%0d rpc=%h rdy=%0d bad=%0d exp 0 0 1 2 %h 3 0", o_wen_n, o_rdw_n, o_fl_n, o_fl_c, o_rpc, o_rdy, o_bad, tgt);
            end
        end
    endtask
    task automatic test_reserved();
        logic [XL-1:0] pc;
        for (int n = 0; n < 6; n++) begin
            pc = {$urandom, $urandom};
            run_instr(2'd3, 3'($urandom), 12'($urandom), 5'($urandom), {$urandom, $urandom}, 5'($urandom), pc, {$urandom, $urandom}, 1'b0);
            chk++;
            if ({o_exc_n, o_wen_n, o_rdw_n, o_fl_n, o_fl_c, o_rpc, o_rdy, o_bad} !== {32'd0, 32'd0, 32'd0, 32'd1, 32'd1, pc + 64'd4, 32'd2, 32'd0}) begin
                err++; $display("FAIL reserved got exc=%0d wen=%0d rdw=%0d fl=%0d fc=%0d rpc=%h rdy=%0d bad=%0d exp 0 0 0 1 1 %h 2 0", o_exc_n, o_wen_n, o_rdw_n, o_fl_n, o_fl_c, o_rpc, o_rdy, o_bad, pc + 64'd4);
            end
        end
    endtask
    task automatic test_back_to_back();
        int pulses;
        test_csr(8, 1'b1);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (csr_wen || rd_wen || flush || csr_excep_op != 2'd0 || in_ready !== 1'b1) pulses++;
        end
        chk++;
        if (pulses != 0) begin
            err++; $display("FAIL idle_after_hold got %0d busy/pulse cycles exp 0", pulses);
        end
    endtask
    task automatic test_reset_write();
        int pulses;
        in_valid = 1'b1; in_kind = 2'd0; in_funct3 = 3'b001; in_csr_addr = 12'h305; in_rs1_idx = 5'd1;
        in_rs1_val = 64'h1234; in_rd = 5'd5; in_pc = 64'h4000; csr_rdata = 64'h77;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk++;
            if ({csr_wen, rd_wen, csr_excep_op, flush, redirect_valid, csr_wdata, rd_data, redirect_pc} !== '0) begin
                err++; $display("FAIL reset_in_write got wen=%b rdw=%b fl=%b wd=%h exp all zero", csr_wen, rd_wen, flush, csr_wdata);
            end
        end
        reset = 1'b0;
        pulses = 0;
        @(negedge clk);
        chk++;
        if (in_ready !== 1'b1) begin
            err++; $display("FAIL ready_after_reset got %b exp 1", in_ready);
        end
        repeat (5) begin
            if (csr_wen || rd_wen || flush || redirect_valid) pulses++;
            @(negedge clk);
        end
        chk++;
        if (pulses != 0) begin
            err++; $display("FAIL aborted_pulses got %0d exp 0", pulses);
        end
    endtask
    initial begin
        reset = 1'b1; in_valid = 1'b0; in_kind = '0; in_funct3 = '0; in_csr_addr = '0; in_rs1_idx = '0;
        in_rs1_val = '0; in_rd = '0; in_pc = '0; csr_rdata = '0; csr_mtvec = '0; csr_mepc = '0;
        test_reset();
        test_directed();
        test_csr(24, 1'b0);
        test_trap();
        test_reserved();
        test_back_to_back();
        test_reset_write();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule

// File: doc/csr_commit.md
CSR_COMMIT -- requirements
Module: csr_commit

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/PC width.
REQ-002 SHALL have clk input 1, clock; reset input 1, synchronous, active-high reset.
REQ-003 SHALL have in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-004 SHALL have in_kind input 2: 0=CSR, 1=ECALL, 2=MRET, 3=reserved (no-op).
REQ-005 SHALL have in_funct3 input 3, in_csr_addr input 12, in_rs1_idx input 5, in_rs1_val input XLEN, in_rd input 5, in_pc input XLEN.
REQ-006 SHALL have csr_raddr output 12, csr_rdata input XLEN, csr_waddr output 12, csr_wen output 1 and csr_wdata output XLEN to the CSR file.
REQ-007 SHALL have csr_excep_op output 2 (0=NONE, 1=ECALL, 2=MRET), csr_pc output XLEN (trap PC), csr_mtvec input XLEN and csr_mepc input XLEN.
REQ-008 SHALL have rd_wen output 1, rd_addr output 5 and rd_data output XLEN, the GPR writeback.
REQ-009 SHALL have flush output 1, redirect_valid output 1 and redirect_pc output XLEN.

Function
REQ-010 SHALL implement FSM states IDLE, READ, WRITE, TRAP and FLUSH.
REQ-011 IDLE: in_ready=1; on in_valid, latch all in_* fields; kind CSR -> READ, ECALL/MRET -> TRAP, reserved -> FLUSH.
REQ-012 in_ready SHALL be 0 in every state other than IDLE; in_* SHALL be ignored outside IDLE.
REQ-013 csr_raddr SHALL equal the latched in_csr_addr in all states; csr_pc SHALL equal the latched pc.
REQ-014 READ: SHALL capture csr_rdata into register old; next state WRITE.
REQ-015 Source operand src SHALL be: funct3[2]=0 -> latched rs1_val; funct3[2]=1 -> rs1_idx zero-extended to XLEN (zimm).
REQ-016 WRITE: csr_wdata SHALL be funct3[1:0]=01 -> src; 10 -> old|src; 11 -> old&~src; csr_waddr SHALL equal the latched addr.
REQ-017 WRITE: csr_wen SHALL be 1 for funct3[1:0]=01, and for 10/11 only when rs1_idx!=0; funct3[1:0]=00 SHALL give csr_wen=0 and rd_wen=0.
REQ-018 WRITE: rd_wen SHALL be 1 iff rd!=0 and funct3[1:0]!=00, with rd_addr=rd and rd_data=old; the writeback is independent of csr_wen.
REQ-019 WRITE: target SHALL be pc+4, modulo 2^XLEN; next state FLUSH.
REQ-020 TRAP: csr_excep_op SHALL be ECALL or MRET for exactly this one cycle.
REQ-021 TRAP: target SHALL latch {csr_mtvec[XLEN-1:2],2'b00} for ECALL or csr_mepc for MRET, sampled in this cycle before the CSR update.
REQ-022 TRAP: next state FLUSH.
REQ-023 Reserved kind: target SHALL be pc+4; no CSR or GPR write SHALL occur.
REQ-024 FLUSH: flush=1, redirect_valid=1 and redirect_pc=target for exactly one cycle; next state IDLE.
REQ-025 csr_wen, rd_wen, csr_excep_op, flush and redirect_valid SHALL be 0 in all states/cycles not named above; each instruction SHALL produce at most one of each pulse.
REQ-026 Latency from the accept cycle T: CSR op is READ T+1, WRITE T+2, FLUSH T+3, in_ready T+4; ECALL/MRET is TRAP T+1, FLUSH T+2, in_ready T+3.
REQ-027 Unimplemented CSR addresses SHALL be processed normally, reading the value the CSR file returns (0); no illegal-instruction detection in this block.

Reset
REQ-028 When reset=1 at a clock edge: state=IDLE and all latched fields, old and target cleared to 0.
REQ-029 During and after reset: csr_wen=0, rd_wen=0, csr_excep_op=0, flush=0, redirect_valid=0 and all data/address outputs 0; in_ready=1 from the first cycle after reset deasserts.
REQ-030 Reset asserted in any state SHALL abort the operation with no further write or redirect pulse.

Verification
REQ-031 CSRRW mtvec(0x305), rs1_val=0x8000_0100, rd=5, csr_rdata=0x40, pc=0x1000 -> T+2: csr_wen=1, csr_wdata=0x8000_0100, rd_wen=1, rd_data=0x40; T+3: redirect_pc=0x1004.
REQ-032 CSRRS with rs1_idx=0, rd=3, csr_rdata=0x1800 -> csr_wen=0, rd_wen=1, rd_data=0x1800; CSRRCI zimm=0x8 on old=0x88 -> csr_wdata=0x80.
REQ-033 ECALL at pc=0x2000, csr_mtvec=0x3001 -> T+1: csr_excep_op=1, csr_pc=0x2000; T+2: flush=1, redirect_pc=0x3000.
REQ-034 MRET, csr_mepc=0x2004 -> T+1: csr_excep_op=2; T+2: redirect_pc=0x2004; in_ready=1 at T+3.
REQ-035 Reset in WRITE state -> no csr_wen/rd_wen/flush pulse; in_ready=1 in the cycle after reset deasserts; in_valid held high during the busy window is accepted only once.
REQ-036 pc=0xFFFF_FFFF_FFFF_FFFC, CSRRW to 0x340 -> redirect_pc=0x0 (wrap).
